// File: rtl/issue_refill_pkg.sv
// Shared slot-state encoding and round-robin helper for the issue refill controller.
package issue_refill_pkg;

    localparam int unsigned WF_STATE_W = 3;

    typedef enum logic [WF_STATE_W-1:0] {
        WF_IDLE    = 3'd0,
        WF_NEED    = 3'd1,
        WF_PEND    = 3'd2,
        WF_FULL    = 3'd3,
        WF_BRANCH  = 3'd4,
        WF_BARRIER = 3'd5
    } wf_state_e;

    // Slot after 'id' in round-robin order, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
        if (id + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return id + 32'd1;
        end
    endfunction

endpackage

// File: rtl/issue_wave_refill_ctrl_if.sv
// Valid/ready refill request channel from the refill controller to fetch.
interface issue_wave_refill_ctrl_if #(
    parameter int unsigned WF_ID_W = 6
);
    logic               fetch_req_valid;
    logic [WF_ID_W-1:0] fetch_req_wfid;
    logic               fetch_req_ready;

    modport master (output fetch_req_valid, output fetch_req_wfid, input fetch_req_ready);
    modport slave  (input fetch_req_valid, input fetch_req_wfid, output fetch_req_ready);
endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin picker: first requesting slot at or after ptr, wrapping at N.
module rr_arbiter_n #(
    parameter int unsigned N    = 40,
    parameter int unsigned ID_W = 6
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id
);

    // Scan N slots starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned sum;
        logic [ID_W-1:0] idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        sum         = 32'd0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end else begin
                sum = sum;
            end
            idx = ID_W'(sum);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/issue_wave_refill_ctrl.sv
// Per-wavefront refill state tracking plus registered round-robin fetch request.
// ISSUE_REFILL_BARRIER_EN enables the BARRIER state and the barrier retire inputs.
module issue_wave_refill_ctrl
    import issue_refill_pkg::*;
#(
    parameter int unsigned NUM_WF  = 40,
    parameter int unsigned WF_ID_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic [WF_ID_W-1:0]  alloc_wfid,
    input  logic                done_en,
    input  logic [WF_ID_W-1:0]  done_wfid,
    input  logic                fill_en,
    input  logic [WF_ID_W-1:0]  fill_wfid,
    input  logic                issue_en,
    input  logic [WF_ID_W-1:0]  issue_wfid,
    input  logic                issue_branch,
    input  logic                issue_barrier,
    input  logic                waitcnt_en,
    input  logic [WF_ID_W-1:0]  waitcnt_wfid,
    input  logic                branch_retire_en,
    input  logic [WF_ID_W-1:0]  branch_retire_wfid,
    input  logic                barrier_retire_en,
    input  logic [NUM_WF-1:0]   barrier_retire_bitmap,
    issue_wave_refill_ctrl_if.master fetch_if,
    output logic [NUM_WF-1:0]   wave_busy
);

    logic               valid_q, valid_d;
    logic [WF_ID_W-1:0] wfid_q, wfid_d;
    logic [WF_ID_W-1:0] ptr_q, ptr_d;
    logic               accept_s;
    logic [NUM_WF-1:0]  req_s;
    logic [NUM_WF-1:0]  bad_evt_s;
    logic               grant_valid_s;
    logic [WF_ID_W-1:0] grant_id_s;

    assign accept_s = valid_q && fetch_if.fetch_req_ready;

`ifndef ISSUE_REFILL_BARRIER_EN
    logic unused_barrier_s;
    assign unused_barrier_s = ^{issue_barrier, barrier_retire_en, barrier_retire_bitmap};
`endif

    for (genvar i = 0; i < NUM_WF; i++) begin : g_slot
        localparam logic [WF_ID_W-1:0] SLOT_ID = WF_ID_W'(i);

        wf_state_e state_q, state_d;
        logic      busy_q;
        logic      alloc_hit_s, done_hit_s, fill_hit_s, issue_hit_s;
        logic      wait_hit_s, br_hit_s, bar_hit_s, acc_hit_s;

        // Out-of-range ids never match because SLOT_ID < NUM_WF.
        assign alloc_hit_s = alloc_en && (alloc_wfid == SLOT_ID);
        assign done_hit_s  = done_en && (done_wfid == SLOT_ID);
        assign fill_hit_s  = fill_en && (fill_wfid == SLOT_ID);
        assign issue_hit_s = issue_en && (issue_wfid == SLOT_ID);
        assign wait_hit_s  = waitcnt_en && (waitcnt_wfid == SLOT_ID);
        assign br_hit_s    = branch_retire_en && (branch_retire_wfid == SLOT_ID);
        assign acc_hit_s   = accept_s && (wfid_q == SLOT_ID);
`ifdef ISSUE_REFILL_BARRIER_EN
        assign bar_hit_s   = barrier_retire_en && barrier_retire_bitmap[i];
`else
        assign bar_hit_s   = 1'b0;
`endif

        // A slot being accepted or retired this cycle must not be granted again.
        assign req_s[i] = (state_q == WF_NEED) && !done_hit_s && !acc_hit_s;

        // Any event that cannot move this slot is dropped; acceptance masks a same-cycle fill.
        assign bad_evt_s[i] = !done_hit_s && (
            (alloc_hit_s && (state_q != WF_IDLE)) ||
            (fill_hit_s  && (state_q != WF_PEND) && !acc_hit_s) ||
            (wait_hit_s  && (state_q != WF_PEND)) ||
            (issue_hit_s && (state_q != WF_FULL)) ||
            (br_hit_s    && (state_q != WF_BRANCH)) ||
            (bar_hit_s   && (state_q != WF_BARRIER)));

        // Per-slot next state; done overrides every other event.
        always_comb begin
            state_d = state_q;
            if (done_hit_s) begin
                state_d = WF_IDLE;
            end else begin
                case (state_q)
                    WF_IDLE:    if (alloc_hit_s) state_d = WF_NEED;   else state_d = state_q;
                    WF_NEED:    if (acc_hit_s)   state_d = WF_PEND;   else state_d = state_q;
                    WF_PEND: begin
                        if (fill_hit_s) begin
                            state_d = WF_FULL;
                        end else if (wait_hit_s) begin
                            state_d = WF_NEED;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    WF_FULL: begin
                        if (!issue_hit_s) begin
                            state_d = state_q;
                        end else if (issue_branch) begin
                            state_d = WF_BRANCH;
`ifdef ISSUE_REFILL_BARRIER_EN
                        end else if (issue_barrier) begin
                            state_d = WF_BARRIER;
`endif
                        end else begin
                            state_d = WF_NEED;
                        end
                    end
                    WF_BRANCH:  if (br_hit_s)    state_d = WF_NEED;   else state_d = state_q;
                    WF_BARRIER: if (bar_hit_s)   state_d = WF_NEED;   else state_d = state_q;
                    default:    state_d = WF_IDLE;
                endcase
            end
        end

        // Slot state and registered busy flag.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= WF_IDLE;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                busy_q  <= (state_d != WF_IDLE);
            end
        end

        assign wave_busy[i] = busy_q;
    end

    rr_arbiter_n #(
        .N    (NUM_WF),
        .ID_W (WF_ID_W)
    ) u_arb (
        .req         (req_s),
        .ptr         (ptr_d),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Request hold/withdraw/re-arbitrate; arbitration uses the post-acceptance pointer.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        wfid_d  = wfid_q;
        if (accept_s) begin
            ptr_d = WF_ID_W'(rr_next(32'(wfid_q), NUM_WF));
        end else begin
            ptr_d = ptr_q;
        end
        if (valid_q && !fetch_if.fetch_req_ready) begin
            if (done_en && (done_wfid == wfid_q)) begin
                valid_d = 1'b0;
            end else begin
                valid_d = 1'b1;
            end
        end else begin
            valid_d = grant_valid_s;
            if (grant_valid_s) begin
                wfid_d = grant_id_s;
            end else begin
                wfid_d = wfid_q;
            end
        end
    end

    // Request channel and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wfid_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wfid_q  <= wfid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign fetch_if.fetch_req_valid = valid_q;
    assign fetch_if.fetch_req_wfid  = wfid_q;

`ifndef SYNTHESIS
    a_evt_legal: assert property (@(posedge clk) disable iff (rst) bad_evt_s == '0)
        else $error("refill event ignored: slot state does not accept it (mask %h)", bad_evt_s);
`endif

endmodule
